// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding imem fetch at a time,
// buffers DEPTH instructions toward decode. Optional macro FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign,
  output logic [31:0] misalign_addr
);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [1:0]    state, state_nxt;
  logic          armed;
  logic [31:0]   fetch_pc, issued_pc, tgt;
  entry_t        q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          gnt_ok, push, pop, bad, halted, halt_nxt;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt = redirect_pc;
  assign bad = |redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted        <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else if (redirect_valid) begin
      halted   <= bad;
      misalign <= bad;
      if (bad) misalign_addr <= redirect_pc;
    end
  end
`else
  assign tgt           = redirect_pc & 32'hFFFF_FFFC;
  assign bad           = 1'b0;
  assign halted        = 1'b0;
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

  // armed keeps imem_req low while reset is held and for the release cycle
  assign imem_req  = (state == REQ) && armed;
  assign imem_addr = fetch_pc;
  assign gnt_ok    = imem_req && imem_gnt;
  assign halt_nxt  = redirect_valid ? bad : halted;

  assign if_valid  = (count != '0);
  assign if_instr  = q[rd_ptr].instr;
  assign if_pc     = q[rd_ptr].pc;

  assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop       = if_valid && if_ready && !redirect_valid;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (redirect_valid)                  state_nxt = halt_nxt ? IDLE : REQ;
        else if (!halted && (count < FULL))  state_nxt = REQ;
      REQ:
        if (gnt_ok)                          state_nxt = redirect_valid ? DROP : WAIT;
        else if (redirect_valid)             state_nxt = halt_nxt ? IDLE : REQ;
      WAIT:
        if (imem_rvalid) begin
          if (redirect_valid)                state_nxt = halt_nxt ? IDLE : REQ;
          else                               state_nxt = (count_nxt < FULL) ? REQ : IDLE;
        end else if (redirect_valid)         state_nxt = DROP;
      DROP:
        // the flushed fetch must drain before anything new goes out
        if (imem_rvalid)                     state_nxt = halt_nxt ? IDLE : REQ;
      default:                               state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REQ;
      armed     <= 1'b0;
      fetch_pc  <= RESET_PC;
      issued_pc <= '0;
    end else begin
      armed <= 1'b1;
      state <= state_nxt;
      if (redirect_valid)  fetch_pc <= tgt;
      else if (gnt_ok)     fetch_pc <= fetch_pc + 32'd4;
      if (gnt_ok)          issued_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= '{pc: issued_pc, instr: imem_rdata};
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory responder with programmable latency plus a stream model
// (delivered PCs run sequentially from reset/redirect target, data = mem_word(pc)).
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        misalign;
  logic [31:0] misalign_addr;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  int          vectors = 0, miscompares = 0, cyc = 0, lat = 1;
  bit          ready_en = 1'b1, gnt_en = 1'b1, redir_now = 1'b0, rst_now = 1'b1;
  logic [31:0] redir_tgt = '0;
  int          mq_due[$];
  logic [31:0] mq_addr[$];
  logic [31:0] dlv_pc[$];
  int          dlv_cyc[$];
  logic [31:0] gnt_log[$];
  logic [31:0] exp_pc = RESET_PC, prev_addr = '0;
  bit          expect_empty = 1'b0, halted = 1'b0, prev_hold = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic chk_dlv(input string name, input int idx, input logic [31:0] exp);
    if (dlv_pc.size() > idx) chk(name, dlv_pc[idx], exp);
    else begin
      vectors++;
      miscompares++;
      $display("FAIL %s: delivery #%0d never arrived, want %h", name, idx, exp);
    end
  endtask

  // One clock: drive inputs and memory at negedge, then check DUT against the stream model.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    rst_n          = !rst_now;
    if_ready       = ready_en;
    redirect_valid = redir_now;
    redirect_pc    = redir_tgt;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
      void'(mq_due.pop_front());
      void'(mq_addr.pop_front());
    end
    imem_gnt = gnt_en && imem_req && !rst_now;
    if (imem_gnt) begin
      mq_due.push_back(cyc + lat);
      mq_addr.push_back(imem_addr);
      gnt_log.push_back(imem_addr);
    end
    if (rst_now) begin
      exp_pc = RESET_PC; expect_empty = 1'b0; halted = 1'b0; prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk1("addr_hold_req", imem_req, 1'b1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (expect_empty) chk1("flush_empty", if_valid, 1'b0);
      if (halted) chk1("halt_no_req", imem_req, 1'b0);
      expect_empty = 1'b0;
      if (redir_now) begin
        expect_empty = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        halted = (redir_tgt[1:0] != 2'b00);
        exp_pc = redir_tgt;
`else
        exp_pc = {redir_tgt[31:2], 2'b00};
`endif
      end else if (if_valid && if_ready) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, mem_word(exp_pc));
        dlv_pc.push_back(if_pc);
        dlv_cyc.push_back(cyc);
        exp_pc += 32'd4;
      end
      prev_hold = imem_req && !imem_gnt && !redir_now;
      prev_addr = imem_addr;
    end
    redir_now = 1'b0;
  endtask

  task automatic do_reset(input bit clear_mem);
    rst_now = 1'b1;
    cycle();
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk1("rst_misalign", misalign, 1'b0);
    chk("rst_misalign_addr", misalign_addr, 32'h0);
    rst_now = 1'b0;
    if (clear_mem) begin mq_due.delete(); mq_addr.delete(); end
    dlv_pc.delete(); dlv_cyc.delete(); gnt_log.delete();
    cycle();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redir_tgt = pc;
    redir_now = 1'b1;
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    #2 rst_n = 1'b0;

    // Reset release and streaming at one instruction per two cycles
    do_reset(1'b1);
    chk1("req_low_release", imem_req, 1'b0);
    cycle();
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, RESET_PC);
    repeat (10) cycle();
    chk_dlv("t1_pc0", 0, 32'h0);
    chk_dlv("t1_pc1", 1, 32'h4);
    chk_dlv("t1_pc2", 2, 32'h8);
    chk_dlv("t1_pc3", 3, 32'hC);
    if (dlv_cyc.size() >= 3) begin
      chk("t1_rate01", 32'(dlv_cyc[1] - dlv_cyc[0]), 32'd2);
      chk("t1_rate12", 32'(dlv_cyc[2] - dlv_cyc[1]), 32'd2);
    end

    // Decode stalled: queue fills with 0,4 and fetch stops, then resumes at 8
    do_reset(1'b1);
    ready_en = 1'b0;
    repeat (10) cycle();
    chk1("t2_valid", if_valid, 1'b1);
    chk("t2_head_pc", if_pc, 32'h0);
    chk1("t2_req_off", imem_req, 1'b0);
    chk("t2_grants", 32'(gnt_log.size()), 32'd2);
    ready_en = 1'b1;
    repeat (10) cycle();
    if (gnt_log.size() >= 3) chk("t2_resume_addr", gnt_log[2], 32'h8);
    else chk("t2_resume_grants", 32'(gnt_log.size()), 32'd3);
    chk_dlv("t2_pc2", 2, 32'h8);

    // Redirect while waiting on the response for 0x8 (latency 3)
    do_reset(1'b1);
    lat = 3; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (mq_addr.size() > 0 && mq_addr[0] == 32'h8 && mq_due[0] > cyc + 1) found = 1'b1;
    end
    chk1("t3_wait8_seen", found, 1'b1);
    redirect(32'h100);
    repeat (20) cycle();
    chk_dlv("t3_pc1", 1, 32'h4);
    chk_dlv("t3_target", 2, 32'h100);

    // Redirect coinciding with rvalid and a pop (latency 1)
    do_reset(1'b1);
    lat = 1; ready_en = 1'b0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (mq_due.size() > 0 && mq_due[0] == cyc + 1 && if_valid) found = 1'b1;
    end
    chk1("t4_collision_seen", found, 1'b1);
    ready_en = 1'b1;
    redirect(32'h200);
    repeat (12) cycle();
    chk_dlv("t4_first", 0, 32'h200);
    chk_dlv("t4_second", 1, 32'h204);

    // Address wrap at the top of the space
    dlv_pc.delete(); dlv_cyc.delete();
    redirect(32'hFFFF_FFFC);
    repeat (12) cycle();
    chk_dlv("t5_top", 0, 32'hFFFF_FFFC);
    chk_dlv("t5_wrap", 1, 32'h0);

    // Grant withheld: address must hold, stream continues afterward
    gnt_en = 1'b0;
    repeat (6) cycle();
    chk1("t6_req_pending", imem_req, 1'b1);
    gnt_en = 1'b1;
    repeat (8) cycle();

    // Misaligned redirect target
    do_reset(1'b1);
    repeat (5) cycle();
    dlv_pc.delete(); dlv_cyc.delete();
    redirect(32'h102);
    cycle();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("t7_misalign", misalign, 1'b1);
    chk("t7_misalign_addr", misalign_addr, 32'h102);
    repeat (6) cycle();
    chk("t7_no_delivery", 32'(dlv_pc.size()), 32'd0);
    redirect(32'h104);
    cycle();
    chk1("t7_cleared", misalign, 1'b0);
    repeat (8) cycle();
    chk_dlv("t7_resume", 0, 32'h104);
`else
    chk1("t7_misalign_tied", misalign, 1'b0);
    chk("t7_misalign_addr_tied", misalign_addr, 32'h0);
    repeat (8) cycle();
    chk_dlv("t7_aligned", 0, 32'h100);
`endif

    // Reset while a fetch is in flight; its late response must be ignored
    lat = 3; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (mq_due.size() > 0 && mq_due[0] > cyc + 1) found = 1'b1;
    end
    chk1("t8_inflight_seen", found, 1'b1);
    do_reset(1'b0);
    repeat (20) cycle();
    chk_dlv("t8_restart0", 0, RESET_PC);
    chk_dlv("t8_restart1", 1, RESET_PC + 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer at the front of the RISC-V core. It owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. It buffers returned instructions in a 2-entry queue toward decode. It also accepts the next-PC redirect produced by the branch unit, flushing buffered and in-flight fetches on a taken branch.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, instruction queue entries (power of two, ≥2)

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  returned instruction word
- redirect_valid  in  1  branch unit: taken branch/jump, one-cycle pulse
- redirect_pc  in  32  branch unit: target PC
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_instr  out  32  queue head instruction
- if_pc  out  32  address of if_instr
- misalign  out  1  sticky misaligned-target flag
- misalign_addr  out  32  offending target

## Operation
- Registers: fetch_pc, state, queue (DEPTH × {pc, instr}), count.
- At most one request outstanding (granted, response pending).
- States:
  - IDLE: no request. Go to REQ when count < DEPTH or on redirect.
  - REQ: imem_req=1, imem_addr=fetch_pc. On gnt: fetch_pc += 4, latch issued address, go to WAIT.
  - WAIT: on rvalid, push {issued address, rdata}. Then go to REQ if count-after-push < DEPTH, else IDLE.
  - DROP: response belongs to a flushed fetch. On rvalid, discard the data and go to REQ.
- Redirect, any state: queue flushed (count=0) and fetch_pc=redirect_pc on the next edge.
  - REQ, no gnt: stay in REQ with the new address; the ungranted request is abandoned.
  - REQ with gnt same cycle: go to DROP.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid same cycle: discard the data, go to REQ.
  - DROP: stay in DROP.
  - IDLE: go to REQ.
- Queue behaviour:
  - Pop when if_valid && if_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Full queue blocks further issue (IDLE), so a push never overflows.
  - Redirect overrides a same-cycle pop and push.
- Address arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0.
  - misalign=0, misalign_addr=0.
  - state=REQ, fetch_pc=RESET_PC, count=0.
- First imem_req rises on the first clock edge after rst_n deasserts.
- imem_addr is held stable while imem_req=1 and imem_gnt=0, except on redirect.
- Response may arrive 1 or more cycles after gnt. A response in the grant cycle is a protocol error and is ignored.
- Queue output is registered: an instruction with rvalid at edge N appears on if_valid/if_instr after edge N.
- Throughput with single-cycle memory: 1 instruction per 2 cycles.
- Redirect at edge N: if_valid=0 after N. The request to the target is visible after N when state is REQ/IDLE, or after the dropped response arrives.
- Reset mid-operation: everything returns to reset values immediately. Any late response is ignored, since the state is REQ and not WAIT.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - Redirect with redirect_pc[1:0]≠0: flush, set misalign=1 and misalign_addr=redirect_pc.
  - Enter IDLE with fetching halted. An in-flight fetch still goes through DROP first.
  - The next aligned redirect clears misalign and resumes fetching.
- Not defined:
  - redirect_pc[1:0] is forced to 00.
  - misalign and misalign_addr are tied to 0.

## Test plan
- Reset release, RESET_PC=0, memory gnt immediate, rvalid one cycle later, if_ready=1 -> if_pc sequence 0,4,8,C, one instruction every 2 cycles.
- if_ready=0 held -> two instructions queued (pc 0,4), imem_req drops. Raise if_ready -> fetch resumes at 8 with no loss or duplication.
- Redirect to 0x100 while in WAIT for 0x8 -> data for 0x8 discarded. Next if_pc=0x100, queue empty in between.
- Redirect to 0x200 in the same cycle as rvalid and pop -> no instruction delivered except 0x200 onward.
- fetch_pc=32'hFFFF_FFFC -> next fetch address 0x0.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign=1, misalign_addr=0x102, no imem_req. Redirect to 0x104 -> misalign=0, fetch at 0x104.
